eth_tx_arbiter: RTL
===================

Name: eth_tx_arbiter

Overview:
- Packet-granular 2:1 round-robin arbiter that shares one QSFP CMAC TX AXI-Stream port between two requesters, e.g. the RX loopback path (port 0) and the host/PCIe injection path (port 1).
- Sits between the requesters and the ethernet_subsys s_qsfpN_axis_* inputs, with one instance per QSFP.
- Never interleaves beats of different packets; a grant holds until the granted packet's tlast beat.
- Provides a registered output stage, a TX enable gate and per-port packet counters.

Parameters:
- DATA_WIDTH, 512, AXIS tdata width (CMAC segment).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 17, tuser width; passed through untouched.
- CNT_WIDTH, 32, width of the per-port packet counters.

Ports:
- clk_161mhz_in  in  1  single clock for the block.
- rstn_161mhz_in  in  1  reset, asynchronous, active-low.
- tx_enable_in  in  1  high = new packets may be granted.
- s0_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA/KEEP/1/1/1/USER  requester 0.
- s1_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA/KEEP/1/1/1/USER  requester 1.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  DATA/KEEP/1/1/1/USER  to CMAC TX.
- busy_out  out  1  high while a packet is locked (ST_LOCK0/ST_LOCK1).
- pkt_cnt0_out, pkt_cnt1_out  out  CNT_WIDTH  tlast beats forwarded from each port.

Behaviour:
- Reset (async assert, deassertion synchronous to clk):
  - m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0, s0/s1_axis_tready=0.
  - busy_out=0, both counters=0, state=ST_IDLE, last_grant=1 (so port 0 wins the first tie).
  - Reset mid-packet discards the partial packet. No recovery of the tail; the next grant restarts from the requesters' current beat.
- Output stage: a single register slot.
  - slot_free = ~m_axis_tvalid | m_axis_tready.
  - An accepted input beat appears on m_axis_* on the next cycle. Latency is exactly 1 cycle.
  - Full throughput: back-to-back beats with no bubbles, within a packet and across packet boundaries.
  - m_axis_* stays stable while m_axis_tvalid=1 and m_axis_tready=0.
- Grant select, combinational, evaluated only in ST_IDLE:
  - No grant if tx_enable_in=0.
  - Only one sN_axis_tvalid high: that port is granted.
  - Both high: the port != last_grant is granted.
  - Neither high: no grant.
- tready: sN_axis_tready = slot_free & (port N granted in IDLE, or state == ST_LOCKN). The non-granted port's tready is 0.
- State machine (ST_IDLE, ST_LOCK0, ST_LOCK1):
  - ST_IDLE: the first beat of the granted port is accepted in the same cycle (no bubble).
    - If that beat has tlast=0: move to ST_LOCKN.
    - If tlast=1: stay in ST_IDLE.
    - On accepting the first beat, last_grant <= N.
  - ST_LOCKN: accept port N beats while slot_free. On acceptance of the tlast beat, return to ST_IDLE. Port N tvalid low mid-packet means wait in ST_LOCKN; the other port is never granted.
  - tx_enable_in falling while in ST_LOCKN: the current packet completes, then no new grant is made. Rising again: arbitration resumes on the same cycle.
  - A single-beat packet followed by the other port's packet: arbitrated on the next cycle with no gap.
- Counters: pkt_cnt0_out/pkt_cnt1_out increment by 1 when a tlast beat is accepted from that port (input handshake). They wrap modulo 2^CNT_WIDTH.
- busy_out = (state != ST_IDLE), registered with the state.
- tdata/tkeep/tuser/tlast are copied unchanged; no tkeep checking.

Test Plan:
- Reset then s0 sends a 4-beat packet (tdata=1..4), m_tready=1 -> m_axis beats 1..4 on cycles +1..+4, tlast on beat 4, pkt_cnt0_out=1, busy_out high for 3 cycles.
- s0 and s1 both hold 3-beat packets continuously for 4 packets each -> output order P0,P1,P0,P1,...; no interleaving; 24 consecutive valid beats with zero bubbles; both counters=4.
- m_tready toggles 1,0,0,1 during an s1 packet -> m_axis_* held stable while stalled; s1_tready=0 whenever the slot is occupied and m_tready=0; no beat lost or duplicated.
- tx_enable_in dropped on beat 2 of a 5-beat s0 packet while s1 is pending -> s0 completes all 5 beats, s1_tready stays 0 until enable returns; then s1 is granted the same cycle.
- Reset asserted on beat 3 of a 6-beat packet -> m_axis_tvalid=0 immediately (async), counters=0; after release with both valid, port 0 is granted first.
- Counter wrap with CNT_WIDTH=4: 17 single-beat s1 packets -> pkt_cnt1_out=1.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
//   A 2:1 round-robin arbiter that works on whole packets. It lets two AXI-Stream
//   requesters share one CMAC TX port. Beats from different packets are never
//   interleaved, because a grant is held until the granted packet's tlast beat.
//   A single register slot drives m_axis_*. Each accepted beat shows up there one
//   cycle later, and the block can move one beat per cycle with no bubbles.
//
// Ports
//   clk_161mhz_in, rstn_161mhz_in : clock; asynchronous active-low reset
//   tx_enable_in                  : 1 = new packets may be granted
//   s0_axis_*, s1_axis_*          : requester 0 / requester 1 (AXIS slave)
//   m_axis_*                      : to CMAC TX (AXIS master, registered)
//   busy_out                      : a packet is locked (ST_LOCK0 / ST_LOCK1)
//   pkt_cnt0_out, pkt_cnt1_out    : tlast beats accepted per port (wrapping)
//
// state    | meaning
// ST_IDLE  | no packet open; grant select active, first beat accepted same cycle
// ST_LOCK0 | mid-packet on port 0; only port 0 beats accepted
// ST_LOCK1 | mid-packet on port 1; only port 1 beats accepted
module eth_tx_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 17,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_161mhz_in,
  input  logic                  rstn_161mhz_in,
  input  logic                  tx_enable_in,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic                  s0_axis_tlast,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic                  s1_axis_tlast,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy_out,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0_out,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   out_en;
  logic   slot_free;
  logic   gnt0, gnt1;
  logic   acc0, acc1;

  // out_en keeps both tready outputs low while reset is asserted. Without it,
  // the idle grant path would raise tready during reset.
  always_comb begin
    slot_free = ~m_axis_tvalid | m_axis_tready;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (state == ST_IDLE && tx_enable_in) begin
      if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant))
        gnt0 = 1'b1;
      else if (s1_axis_tvalid)
        gnt1 = 1'b1;
    end
    s0_axis_tready = out_en & slot_free & (gnt0 | (state == ST_LOCK0));
    s1_axis_tready = out_en & slot_free & (gnt1 | (state == ST_LOCK1));
    acc0 = s0_axis_tready & s0_axis_tvalid;
    acc1 = s1_axis_tready & s1_axis_tvalid;

    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (acc0 && !s0_axis_tlast)
          state_nxt = ST_LOCK0;
        else if (acc1 && !s1_axis_tlast)
          state_nxt = ST_LOCK1;
      end
      ST_LOCK0: if (acc0 && s0_axis_tlast) state_nxt = ST_IDLE;
      ST_LOCK1: if (acc1 && s1_axis_tlast) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_161mhz_in or negedge rstn_161mhz_in) begin
    if (!rstn_161mhz_in) begin
      state         <= ST_IDLE;
      busy_out      <= 1'b0;
      last_grant    <= 1'b1;
      out_en        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      pkt_cnt0_out  <= '0;
      pkt_cnt1_out  <= '0;
    end else begin
      out_en   <= 1'b1;
      state    <= state_nxt;
      busy_out <= (state_nxt != ST_IDLE);

      if (acc0) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s0_axis_tdata;
        m_axis_tkeep  <= s0_axis_tkeep;
        m_axis_tlast  <= s0_axis_tlast;
        m_axis_tuser  <= s0_axis_tuser;
      end else if (acc1) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s1_axis_tdata;
        m_axis_tkeep  <= s1_axis_tkeep;
        m_axis_tlast  <= s1_axis_tlast;
        m_axis_tuser  <= s1_axis_tuser;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      // Round-robin pointer moves only on the first beat of a packet.
      if (state == ST_IDLE) begin
        if (acc0)
          last_grant <= 1'b0;
        else if (acc1)
          last_grant <= 1'b1;
      end

      if (acc0 && s0_axis_tlast) pkt_cnt0_out <= pkt_cnt0_out + 1'b1;
      if (acc1 && s1_axis_tlast) pkt_cnt1_out <= pkt_cnt1_out + 1'b1;
    end
  end

endmodule
